weight_mem_loader: RTL and testbench
====================================

# weight_mem_loader

Write-side front end for the local weight memory of the one-layer accelerator. It accepts 32-bit words from the bus/DMA side over a valid/ready handshake. Each word is unpacked into two 16-bit weights, which are issued as single-cycle writes on the weight memory write port (`write_weight_signal` / `write_weight_addr` / `write_weight_data`), starting at a programmed base address. A `done` pulse tells the layer controller when the programmed number of weights has landed, so weight reads can begin.

## Interface
- `MAX_WEIGHTS`, default 2000: depth of the weight memory in 16-bit entries; highest legal write address is `MAX_WEIGHTS-1`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  load request. Sampled only in IDLE.
- `base_addr`  in  16  first weight address. Latched on accepted `start`.
- `weight_count`  in  16  number of 16-bit weights to write. Latched on accepted `start`.
- `in_valid`  in  1  source has a word on `in_data`.
- `in_data`  in  32  packed weights: [15:0] is written first, [31:16] second.
- `in_ready`  out  1  loader accepts a word this cycle.
- `write_weight_signal`  out  1  memory write strobe, one weight per cycle.
- `write_weight_addr`  out  16  memory write address.
- `write_weight_data`  out  16  memory write data.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last weight is written.
- `err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- Registers:
  - state
  - `cur_addr` (16)
  - `remaining` (16)
  - `word_buf` (32)
- The write-port outputs and `in_ready` are decoded from state and registers only. There is no combinational path from any input to any output.
- **IDLE**
  - All outputs are 0.
  - On `start`:
    - If `weight_count==0`, or `base_addr + weight_count > MAX_WEIGHTS` (computed in 17 bits, no wrap), pulse `err` next cycle and stay IDLE.
    - Otherwise latch `cur_addr=base_addr` and `remaining=weight_count`, and go to FETCH.
- **FETCH**
  - `in_ready=1`.
  - On `in_valid`, capture `in_data` into `word_buf` and go to WR_LO.
  - Without `in_valid`, hold; stalls are unbounded.
- **WR_LO**
  - `write_weight_signal=1`, `write_weight_addr=cur_addr`, `write_weight_data=word_buf[15:0]`.
  - Next cycle: `cur_addr+1`, `remaining-1`.
  - If `remaining==1`, go to DONE; else go to WR_HI.
- **WR_HI**
  - Same as WR_LO, but with `word_buf[31:16]`.
  - If `remaining==1`, go to DONE; else go to FETCH.
- **DONE**
  - `done=1` for one cycle, then IDLE.
- **Odd `weight_count`:** the upper half of the final word is discarded, and no write is issued for it.
- **`start` while not IDLE:** ignored. No `err` is raised and the latched values are unchanged.
- **`in_valid` outside FETCH:** ignored, because `in_ready` is 0.
- **Reset, including mid-load:**
  - State goes to IDLE.
  - `cur_addr`, `remaining` and `word_buf` clear to 0.
  - All outputs are 0 immediately (asynchronous).
  - A partially written memory region is left as-is. The controller must restart the load.
- Addresses never exceed `MAX_WEIGHTS-1`. This is guaranteed by the check at `start`.

## Timing
- Accepted `start` in cycle 0 → FETCH with `in_ready=1` in cycle 1.
- Handshake in cycle k → WR_LO in k+1 → WR_HI in k+2 → `in_ready` again in k+3.
- Peak throughput is 2 weights per 3 cycles.
- Last write in cycle m → `done` in cycle m+1 → IDLE in m+2. A new `start` is accepted from m+2.
- Rejected `start` in cycle 0 → `err` in cycle 1. `busy` stays 0 throughout.
- `busy` is high from cycle 1 through the `done` cycle, inclusive.
- Memory write latency: a write presented in cycle n is visible to reads from cycle n+1.

## Test plan
1. **Reset values.** Assert `rst` mid-cycle with no clock edge → `in_ready`, `write_weight_signal`, `busy`, `done` and `err` are all 0 at once.
2. **Even count.**
   - Stimulus: `base_addr=0`, `weight_count=4`, source always valid with words 0x00020001 then 0x00040003.
   - Required: writes (0,0x0001), (1,0x0002), (2,0x0003), (3,0x0004) in cycles 2, 3, 5, 6; `done` in cycle 7; `busy` high in cycles 1-7.
3. **Odd count with a stalled source.**
   - Stimulus: `base_addr=100`, `weight_count=3`; `in_valid` withheld for 5 cycles before each word; words 0xBBBBAAAA then 0xDDDDCCCC.
   - Required: writes (100,0xAAAA), (101,0xBBBB), (102,0xCCCC) only; 0xDDDD is never written; `in_ready` holds 1 through each stall.
4. **Rejection.**
   - Stimulus: `base_addr=1998`, `weight_count=3` → `err` pulse, no writes.
   - Stimulus: `weight_count=0` → `err` pulse.
   - Stimulus: `base_addr=1998`, `weight_count=2` → accepted; writes to 1998 and 1999.
5. **Start while busy.** A second `start` with different arguments during WR_HI → ignored; the original sequence completes unchanged.
6. **Reset mid-load.**
   - Stimulus: assert `rst` in the WR_HI of word 1 of an 8-weight load, then release it.
   - Required: no further writes and no `done`. A fresh load of 2 weights at `base_addr=50` then completes normally.

Source files
------------

// File: rtl/weight_mem_loader.sv
// Weight memory write-side loader: accepts 32-bit words over valid/ready and
// issues them as two consecutive 16-bit writes from a programmed base address.
module weight_mem_loader #(
  parameter int MAX_WEIGHTS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] weight_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        write_weight_signal,
  output logic [15:0] write_weight_addr,
  output logic [15:0] write_weight_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, FETCH, WR_LO, WR_HI, DONE} state_t;

  state_t      state;
  logic [15:0] cur_addr;
  logic [15:0] remaining;
  logic [31:0] word_buf;

  // 17-bit end address so a base near 0xFFFF cannot wrap past the range check
  logic [16:0] end_addr;
  logic        bad_req;
  logic        last;

  assign end_addr = {1'b0, base_addr} + {1'b0, weight_count};
  assign bad_req  = (weight_count == 16'd0) || (end_addr > 17'(MAX_WEIGHTS));
  assign last     = (remaining == 16'd1);

  // Outputs are registered alongside the next state, so each output reflects
  // the state being entered and never depends combinationally on an input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cur_addr            <= '0;
      remaining           <= '0;
      word_buf            <= '0;
      in_ready            <= 1'b0;
      write_weight_signal <= 1'b0;
      write_weight_addr   <= '0;
      write_weight_data   <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
    end else begin
      in_ready            <= 1'b0;
      write_weight_signal <= 1'b0;
      write_weight_addr   <= '0;
      write_weight_data   <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_req) begin
              err <= 1'b1;
            end else begin
              cur_addr  <= base_addr;
              remaining <= weight_count;
              state     <= FETCH;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        FETCH: begin
          busy <= 1'b1;
          if (in_valid) begin
            word_buf            <= in_data;
            state               <= WR_LO;
            write_weight_signal <= 1'b1;
            write_weight_addr   <= cur_addr;
            write_weight_data   <= in_data[15:0];
          end else begin
            in_ready <= 1'b1;
          end
        end
        WR_LO: begin
          busy      <= 1'b1;
          cur_addr  <= cur_addr + 16'd1;
          remaining <= remaining - 16'd1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state               <= WR_HI;
            write_weight_signal <= 1'b1;
            write_weight_addr   <= cur_addr + 16'd1;
            write_weight_data   <= word_buf[31:16];
          end
        end
        WR_HI: begin
          busy      <= 1'b1;
          cur_addr  <= cur_addr + 16'd1;
          remaining <= remaining - 16'd1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= FETCH;
            in_ready <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_mem_loader.sv
// Directed self-checking bench for weight_mem_loader; writes are logged by a
// monitor with their cycle number relative to the start cycle.
module tb_weight_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] weight_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, write_weight_signal, busy, done, err;
  logic [15:0] write_weight_addr, write_weight_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0, done_cyc, busy_first, busy_last, busy_cnt, err_seen;
  logic [31:0] src[4];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];

  weight_mem_loader #(.MAX_WEIGHTS(2000)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .weight_count(weight_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .write_weight_signal(write_weight_signal),
    .write_weight_addr(write_weight_addr), .write_weight_data(write_weight_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write_weight_signal === 1'b1) begin
      log_addr.push_back(write_weight_addr);
      log_data.push_back(write_weight_data);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.push_back(16'h0);
    log_data.delete();
    log_cyc.delete();
  endtask

  // Drives one load: start in cycle 0, then feeds src[] with `stall` idle
  // cycles before each word; optionally pulses a foreign start at inj_cyc.
  task automatic run_load(input logic [15:0] base, input logic [15:0] cnt,
                          input int nwords, input int stall, input int inj_cyc);
    int widx = 0;
    int stallc = 0;
    int rel;
    bit hs;
    clear_log();
    done_cyc = -1; busy_first = -1; busy_last = -1; busy_cnt = 0; err_seen = 0;
    c0 = cyc;
    base_addr = base; weight_count = cnt; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && done_cyc < 0; k++) begin
      rel = cyc - c0;
      if (busy === 1'b1) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
        busy_cnt++;
      end
      if (err === 1'b1) err_seen = 1;
      if (done === 1'b1) done_cyc = rel;
      start = (rel == inj_cyc);
      if (start) begin
        base_addr = 16'd500; weight_count = 16'd1;
      end
      in_valid = 1'b0;
      if (in_ready === 1'b1 && widx < nwords) begin
        if (stallc < stall) stallc++;
        else begin
          in_valid = 1'b1; in_data = src[widx];
        end
      end
      hs = (in_ready === 1'b1) && in_valid;
      tick();
      if (hs) begin
        widx++; stallc = 0;
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({in_ready, write_weight_signal, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold outs=%b want 00000", {in_ready, write_weight_signal, busy, done, err});
    end
    #10 rst = 1'b0;
    tick();
    base_addr = 16'd0; weight_count = 16'd2; start = 1'b1;
    in_valid = 1'b1; in_data = 32'h0000_0007;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (write_weight_signal !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_wr wws=%b busy=%b want 1 1", write_weight_signal, busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, write_weight_signal, busy, done, err} !== 5'b0 ||
        write_weight_addr !== 16'd0 || write_weight_data !== 16'd0) begin
      errors++;
      $display("FAIL async_reset outs=%b addr=%h data=%h want all 0",
               {in_ready, write_weight_signal, busy, done, err}, write_weight_addr, write_weight_data);
    end
    #1 rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_even;
    logic [15:0] ea[4] = '{16'd0, 16'd1, 16'd2, 16'd3};
    logic [15:0] ed[4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    int          ec[4] = '{2, 3, 5, 6};
    src[0] = 32'h0002_0001; src[1] = 32'h0004_0003;
    run_load(16'd0, 16'd4, 2, 0, -1);
    checks++;
    if (log_addr.size() != 4) begin
      errors++; $display("FAIL even_count writes=%0d want 4", log_addr.size());
    end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_cyc[i] - c0 != ec[i]) begin
        errors++;
        $display("FAIL even_wr%0d got (%0d,%h)@%0d want (%0d,%h)@%0d", i,
                 log_addr[i], log_data[i], log_cyc[i] - c0, ea[i], ed[i], ec[i]);
      end
    end
    checks++;
    if (done_cyc != 7) begin
      errors++; $display("FAIL even_done cycle=%0d want 7", done_cyc);
    end
    checks++;
    if (busy_first != 1 || busy_last != 7 || busy_cnt != 7) begin
      errors++;
      $display("FAIL even_busy first=%0d last=%0d n=%0d want 1 7 7", busy_first, busy_last, busy_cnt);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL even_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_odd_stall;
    logic [15:0] ea[3] = '{16'd100, 16'd101, 16'd102};
    logic [15:0] ed[3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    int          ec[3] = '{7, 8, 15};
    src[0] = 32'hBBBB_AAAA; src[1] = 32'hDDDD_CCCC;
    run_load(16'd100, 16'd3, 2, 5, -1);
    checks++;
    if (log_addr.size() != 3) begin
      errors++; $display("FAIL odd_count writes=%0d want 3", log_addr.size());
    end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_cyc[i] - c0 != ec[i]) begin
        errors++;
        $display("FAIL odd_wr%0d got (%0d,%h)@%0d want (%0d,%h)@%0d", i,
                 log_addr[i], log_data[i], log_cyc[i] - c0, ea[i], ed[i], ec[i]);
      end
    end
    checks++;
    if (done_cyc != 16 || busy_cnt != 16) begin
      errors++; $display("FAIL odd_done cycle=%0d busy_n=%0d want 16 16", done_cyc, busy_cnt);
    end
  endtask

  task automatic test_reject;
    logic [15:0] bases[3]  = '{16'd1998, 16'd10, 16'hFFFF};
    logic [15:0] counts[3] = '{16'd3, 16'd0, 16'd2};
    for (int t = 0; t < 3; t++) begin
      clear_log();
      base_addr = bases[t]; weight_count = counts[t]; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reject%0d_err err=%b busy=%b rdy=%b want 1 0 0", t, err, busy, in_ready);
      end
      tick();
      tick();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || log_addr.size() != 0) begin
        errors++;
        $display("FAIL reject%0d_after err=%b busy=%b writes=%0d want 0 0 0", t, err, busy, log_addr.size());
      end
    end
    src[0] = 32'h5678_1234;
    run_load(16'd1998, 16'd2, 1, 0, -1);
    checks++;
    if (log_addr.size() != 2 || err_seen != 0 || done_cyc != 4) begin
      errors++;
      $display("FAIL edge_accept writes=%0d err=%0d done=%0d want 2 0 4", log_addr.size(), err_seen, done_cyc);
    end else begin
      checks++;
      if (log_addr[0] !== 16'd1998 || log_data[0] !== 16'h1234 ||
          log_addr[1] !== 16'd1999 || log_data[1] !== 16'h5678) begin
        errors++;
        $display("FAIL edge_writes got (%0d,%h)(%0d,%h) want (1998,1234)(1999,5678)",
                 log_addr[0], log_data[0], log_addr[1], log_data[1]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic [15:0] ed[4] = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    int          ec[4] = '{2, 3, 5, 6};
    src[0] = 32'h0B0B_0A0A; src[1] = 32'h0D0D_0C0C;
    run_load(16'd10, 16'd4, 2, 0, 3);
    checks++;
    if (log_addr.size() != 4 || err_seen != 0 || done_cyc != 7) begin
      errors++;
      $display("FAIL busy_start writes=%0d err=%0d done=%0d want 4 0 7", log_addr.size(), err_seen, done_cyc);
    end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 16'(10 + i) || log_data[i] !== ed[i] || log_cyc[i] - c0 != ec[i]) begin
        errors++;
        $display("FAIL busy_wr%0d got (%0d,%h)@%0d want (%0d,%h)@%0d", i,
                 log_addr[i], log_data[i], log_cyc[i] - c0, 10 + i, ed[i], ec[i]);
      end
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || log_addr.size() != 4) begin
      errors++; $display("FAIL busy_after busy=%b writes=%0d want 0 4", busy, log_addr.size());
    end
  endtask

  task automatic test_reset_midload;
    int dn = 0;
    clear_log();
    base_addr = 16'd200; weight_count = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h2222_1111;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (write_weight_signal !== 1'b1 || write_weight_addr !== 16'd203 || write_weight_data !== 16'h2222) begin
      errors++;
      $display("FAIL mid_wrhi wws=%b addr=%0d data=%h want 1 203 2222",
               write_weight_signal, write_weight_addr, write_weight_data);
    end
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    in_valid = 1'b0;
    checks++;
    if (log_addr.size() != 3 || dn != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort writes=%0d done=%0d busy=%b want 3 0 0", log_addr.size(), dn, busy);
    end
    src[0] = 32'h0BAD_0ACE;
    run_load(16'd50, 16'd2, 1, 0, -1);
    checks++;
    if (log_addr.size() != 2 || done_cyc != 4) begin
      errors++; $display("FAIL mid_reload writes=%0d done=%0d want 2 4", log_addr.size(), done_cyc);
    end else begin
      checks++;
      if (log_addr[0] !== 16'd50 || log_data[0] !== 16'h0ACE ||
          log_addr[1] !== 16'd51 || log_data[1] !== 16'h0BAD) begin
        errors++;
        $display("FAIL mid_reload_wr got (%0d,%h)(%0d,%h) want (50,0ace)(51,0bad)",
                 log_addr[0], log_data[0], log_addr[1], log_data[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd_stall();
    test_reject();
    test_start_while_busy();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
